i2s_receiver: RTL

//   Deserialises the MCU I2S stream (i2c_mcu_bck/lrck/data) into parallel stereo words.

---
 rtl/i2s_receiver_pkg.sv | 19 +
 rtl/i2s_receiver_if.sv | 28 ++
 rtl/i2s_receiver_sync_edge.sv | 34 +++
 rtl/i2s_receiver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/i2s_receiver_pkg.sv
// Shared types and helpers for the I2S receiver.
package i2s_receiver_pkg;

  typedef logic [5:0] bitcnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam bitcnt_t BITCNT_MAX = 6'd63;

  // Bit counter increment that sticks at BITCNT_MAX.
  function automatic bitcnt_t bitcnt_inc(input bitcnt_t c);
    return (c == BITCNT_MAX) ? c : c + 6'd1;
  endfunction

endpackage

// File: rtl/i2s_receiver_if.sv
// I2S serial lines in, parallel stereo words out.
//
// Handshake: there is no back-pressure. valid is a single-clk pulse that
// marks a new {left, right} word on data; data and bitnum hold until the
// next valid. err is a single-clk pulse and is never high together with valid.
interface i2s_receiver_if #(parameter int WIDTH = 24);
  import i2s_receiver_pkg::*;

  logic                 i2s_bck;
  logic                 i2s_lrck;
  logic                 i2s_data;
  logic [2*WIDTH-1:0]   data;
  logic                 valid;
  bitcnt_t              bitnum;
  logic                 lock;
  logic                 err;

  modport master (
    output i2s_bck, i2s_lrck, i2s_data,
    input  data, valid, bitnum, lock, err
  );

  modport slave (
    input  i2s_bck, i2s_lrck, i2s_data,
    output data, valid, bitnum, lock, err
  );

endinterface

// File: rtl/i2s_receiver_sync_edge.sv
// Two-flop synchroniser with a third stage for edge detection and a
// registered output. EDGE = 0 gives the synchronised level, 1 a rising-edge
// pulse, 2 a falling-edge pulse. Every mode has the same latency, so a level
// instance and an edge instance stay cycle-aligned.
module i2s_receiver_sync_edge #(
  parameter int W    = 1,
  parameter int EDGE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1, s2, s3;

  // Synchroniser chain plus registered level / edge output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      if (EDGE == 1)      q <= s2 & ~s3;
      else if (EDGE == 2) q <= ~s2 & s3;
      else                q <= s2;
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// I2S deserialiser: oversamples bck/lrck/data, assembles left/right words,
// checks that both channels carry the same bit count and tracks lock.
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int TIMEOUT = 1024,
  parameter int LOCK_FR = 2
) (
  input  logic           clk,
  input  logic           reset,
  i2s_receiver_if.slave  bus,
  output i2s_rx_state_t  dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_FR + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_FR);

  logic          tick;
  logic [1:0]    lines;
  logic          lrck_s, data_s;

  i2s_receiver_sync_edge #(.W(1), .EDGE(1)) u_bck (
    .clk (clk), .rst (reset), .d (bus.i2s_bck), .q (tick)
  );

  i2s_receiver_sync_edge #(.W(2), .EDGE(0)) u_lines (
    .clk (clk), .rst (reset), .d ({bus.i2s_lrck, bus.i2s_data}), .q (lines)
  );

  assign lrck_s = lines[1];
  assign data_s = lines[0];

  i2s_rx_state_t       state, state_d;
  logic                lrck_prev;
  logic [WIDTH-1:0]    word, word_cap, word_l;
  bitcnt_t             cnt, cnt_inc, cnt_l;
  logic [GW-1:0]       good, good_inc;
  logic [TW-1:0]       tmo;
  logic [2*WIDTH-1:0]  data_q;
  bitcnt_t             bitnum_q;
  logic                valid_q, err_q, lock_q;
  logic                timeout, boundary;
  logic                latch_l, frame_ok, frame_bad;

  assign timeout  = (tmo == TMO_LIMIT);
  assign boundary = lrck_s ^ lrck_prev;
  assign cnt_inc  = bitcnt_inc(cnt);
  assign good_inc = (good == GOOD_MAX) ? good : good + 1'b1;

  // Current word with this tick's bit written in; bits past WIDTH fall off.
  always_comb begin
    word_cap = word;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(cnt) == WIDTH - 1 - i) word_cap[i] = data_s;
    end
  end

  // Channel FSM: next state plus the latch / frame-result strobes.
  always_comb begin
    state_d   = state;
    latch_l   = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (tick && boundary) begin
      case (state)
        IDLE:  if (!lrck_s) state_d = LEFT;
        LEFT:  if (lrck_s) begin
                 state_d = RIGHT;
                 latch_l = 1'b1;
               end
        RIGHT: if (!lrck_s) begin
                 state_d = LEFT;
                 if (cnt_inc == cnt_l) frame_ok  = 1'b1;
                 else                  frame_bad = 1'b1;
               end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Capture, counters, frame outputs, lock and timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrck_prev <= 1'b0;
      word      <= '0;
      cnt       <= '0;
      word_l    <= '0;
      cnt_l     <= '0;
      good      <= '0;
      tmo       <= '0;
      data_q    <= '0;
      bitnum_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (timeout) begin
        // Stream stalled: drop lock and any partial word; data/bitnum hold.
        tmo    <= '0;
        good   <= '0;
        lock_q <= 1'b0;
        word   <= '0;
        cnt    <= '0;
      end else if (tick) begin
        tmo       <= '0;
        lrck_prev <= lrck_s;
        if (boundary) begin
          word <= '0;
          cnt  <= '0;
        end else begin
          word <= word_cap;
          cnt  <= cnt_inc;
        end
        if (latch_l) begin
          word_l <= word_cap;
          cnt_l  <= cnt_inc;
        end
        if (frame_bad) begin
          err_q  <= 1'b1;
          good   <= '0;
          lock_q <= 1'b0;
        end else if (frame_ok) begin
          data_q   <= {word_l, word_cap};
          bitnum_q <= cnt_inc;
          valid_q  <= 1'b1;
          good     <= good_inc;
          if (good_inc == GOOD_MAX) lock_q <= 1'b1;
        end
      end else begin
        tmo <= tmo + 1'b1;
      end
    end
  end

  assign bus.data   = data_q;
  assign bus.valid  = valid_q;
  assign bus.bitnum = bitnum_q;
  assign bus.lock   = lock_q;
  assign bus.err    = err_q;
  assign dbg_state  = state;

endmodule
